// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: FSM state type and
// common widths used by the feeder and its byte FIFO.
package uart_pkg;

    localparam int BYTE_W = 8;

    // Feeder FSM states. 3-bit encoding; codes 4..7 are unused and are
    // folded back to IDLE by the next-state logic.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_GAP       = 3'd3
    } feeder_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with count-derived full/empty. Pointers wrap naturally because
// DEPTH is a power of two. Head data is visible combinationally on pop_data.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [BYTE_W-1:0]        push_data,
    input  logic                     pop,
    output logic [BYTE_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push while full or a pop while empty is ignored outright.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy next-state; simultaneous push and pop keep count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointer and count registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array is deliberately left without reset; count gates validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds a byte-at-a-time UART transmitter from a FIFO. The FSM pops one byte
// into a holding register, raises data-valid until the transmitter reports
// active, waits for a fresh done pulse, then waits for done to fall again so
// the transmitter's cleanup cycle cannot swallow the next launch.
//
// Handshake: a write transfers on a rising clk edge where i_Wr_Valid and
// o_Wr_Ready are both high; o_Wr_Ready depends only on the occupancy count,
// never on i_Wr_Valid or on a pop in the same cycle.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_Wr_Valid,
    input  logic [7:0]             i_Wr_Byte,
    output logic                   o_Wr_Ready,
    output logic                   o_Overflow,
    output logic [$clog2(DEPTH):0] o_Count,
    output logic                   o_TX_Data_Valid,
    output logic [7:0]             o_TX_Byte,
    input  logic                   i_TX_Active,
    input  logic                   i_TX_Done,
    output logic                   o_Busy
);

    feeder_state_e     state_q, state_d;
    logic              tx_dv_q, tx_dv_d;
    logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic              tx_done_q, tx_done_d;
    logic              overflow_q, overflow_d;

    logic              fifo_pop;
    logic [BYTE_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (i_Wr_Valid),
        .push_data (i_Wr_Byte),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .count     (o_Count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign o_Wr_Ready      = !fifo_full;
    assign o_Overflow      = overflow_q;
    assign o_TX_Data_Valid = tx_dv_q;
    assign o_TX_Byte       = tx_byte_q;
    assign o_Busy          = (state_q != ST_IDLE) || !fifo_empty;

    // Side registers: overflow flag for a rejected offer, and the previous
    // done level used for rising-edge detection in WAIT_DONE.
    always_comb begin
        overflow_d = i_Wr_Valid && fifo_full;
        tx_done_d  = i_TX_Done;
    end

    // Next-state and output logic for the launch sequencer.
    always_comb begin
        state_d   = state_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    tx_byte_d = fifo_rd_data;
                    tx_dv_d   = 1'b1;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // Hold valid until the transmitter has taken the byte.
                tx_dv_d = 1'b1;
                if (i_TX_Active) begin
                    tx_dv_d = 1'b0;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // Only a fresh rising edge counts; a stale high level does not.
                if (i_TX_Done && !tx_done_q) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!i_TX_Done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, holding register and side flags, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= '0;
            tx_done_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            tx_done_q  <= tx_done_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a behavioural UART transmitter (start, 8 data bits
// LSB-first, stop, one cleanup cycle with done held high) and a serial
// decoder feeding a byte scoreboard.
module tb_uart_tx_feeder;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          i_Wr_Valid;
    logic [7:0]    i_Wr_Byte;
    logic          o_Wr_Ready;
    logic          o_Overflow;
    logic [CW-1:0] o_Count;
    logic          o_TX_Data_Valid;
    logic [7:0]    o_TX_Byte;
    logic          tx_active = 1'b0;
    logic          tx_done   = 1'b0;
    logic          o_Busy;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_Wr_Valid      (i_Wr_Valid),
        .i_Wr_Byte       (i_Wr_Byte),
        .o_Wr_Ready      (o_Wr_Ready),
        .o_Overflow      (o_Overflow),
        .o_Count         (o_Count),
        .o_TX_Data_Valid (o_TX_Data_Valid),
        .o_TX_Byte       (o_TX_Byte),
        .i_TX_Active     (tx_active),
        .i_TX_Done       (tx_done),
        .o_Busy          (o_Busy)
    );

    // ---------------- transmitter model ----------------
    int         cpb        = 4;
    int         m_st       = 0;
    int         m_cnt      = 0;
    int         m_idx      = 0;
    logic [7:0] m_byte     = 8'h00;
    logic       tx_serial  = 1'b1;
    int         launch_cnt = 0;

    always @(posedge clk) begin
        case (m_st)
            0: begin
                tx_serial <= 1'b1;
                tx_done   <= 1'b0;
                m_cnt     <= 0;
                m_idx     <= 0;
                if (o_TX_Data_Valid) begin
                    tx_active  <= 1'b1;
                    m_byte     <= o_TX_Byte;
                    launch_cnt <= launch_cnt + 1;
                    m_st       <= 1;
                end
            end
            1: begin
                tx_serial <= 1'b0;
                if (m_cnt < cpb - 1) m_cnt <= m_cnt + 1;
                else begin m_cnt <= 0; m_st <= 2; end
            end
            2: begin
                tx_serial <= m_byte[m_idx];
                if (m_cnt < cpb - 1) m_cnt <= m_cnt + 1;
                else begin
                    m_cnt <= 0;
                    if (m_idx < 7) m_idx <= m_idx + 1;
                    else begin m_idx <= 0; m_st <= 3; end
                end
            end
            3: begin
                tx_serial <= 1'b1;
                if (m_cnt < cpb - 1) m_cnt <= m_cnt + 1;
                else begin
                    m_cnt     <= 0;
                    tx_done   <= 1'b1;
                    tx_active <= 1'b0;
                    m_st      <= 4;
                end
            end
            default: begin
                tx_done <= 1'b1;
                m_st    <= 0;
            end
        endcase
    end

    // ---------------- serial decoder ----------------
    logic [7:0] rx_shift = 8'h00;
    int         rx_cnt   = 0;
    bit         rx_busy  = 1'b0;
    logic [7:0] rx_q[$];

    always @(posedge clk) begin
        if (!rx_busy) begin
            if (tx_serial == 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            for (int k = 0; k < 9; k++) begin
                if (rx_cnt == cpb / 2 + cpb * (k + 1)) begin
                    if (k < 8) rx_shift[k] = tx_serial;
                    else begin
                        rx_q.push_back(rx_shift);
                        rx_busy = 1'b0;
                    end
                end
            end
        end
    end

    // Counts launches that rise while the transmitter still reports done.
    logic prev_dv = 1'b0;
    int   dv_viol = 0;
    always @(negedge clk) begin
        if (o_TX_Data_Valid && !prev_dv && tx_done) dv_viol++;
        prev_dv = o_TX_Data_Valid;
    end

    // ---------------- scoreboard / checks ----------------
    logic [7:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Called at a negedge; applies one cycle of write stimulus.
    task automatic drive_cycle(input logic vld, input logic [7:0] b);
        i_Wr_Valid = vld;
        i_Wr_Byte  = b;
        @(negedge clk);
        i_Wr_Valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int n, input int budget);
        int waited;
        logic [7:0] got;
        logic [7:0] want;
        waited = 0;
        while (rx_q.size() < n && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_rx_timeout"}, int'(rx_q.size() >= n), 1);
        for (int i = 0; i < n; i++) begin
            if (rx_q.size() > 0 && exp_q.size() > 0) begin
                got  = rx_q.pop_front();
                want = exp_q.pop_front();
                check($sformatf("%s_byte%0d", tag, i), int'(got), int'(want));
            end
        end
        waited = 0;
        while ((o_Busy || m_st != 0 || rx_busy) && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_busy_end"}, int'(o_Busy), 0);
        repeat (20) @(negedge clk);
        check({tag, "_no_extra_rx"}, rx_q.size(), 0);
        check({tag, "_exp_left"}, exp_q.size(), 0);
        check({tag, "_dv_during_done"}, dv_viol, 0);
    endtask

    typedef struct {
        logic          vld;
        logic [7:0]    data;
        logic          exp_acc;
        logic          exp_ready;
        logic [CW-1:0] exp_count;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs[10];
    int   base;
    int   waited;
    int   seq[$];
    logic [CW-1:0] last_cnt;
    logic [7:0] b;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fill test: DUT already busy on a long frame, so nothing pops.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b1, 8'(8'hC0 + i), 1'b1, (i < 7) ? 1'b1 : 1'b0,
                        CW'(i + 1), 1'b0};
        end
        vecs[8] = '{1'b1, 8'hEE, 1'b0, 1'b0, CW'(8), 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, CW'(8), 1'b0};

        rst        = 1'b1;
        i_Wr_Valid = 1'b0;
        i_Wr_Byte  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_count", int'(o_Count), 0);
        check("rst_ready", int'(o_Wr_Ready), 1);
        check("rst_dv", int'(o_TX_Data_Valid), 0);
        check("rst_byte", int'(o_TX_Byte), 0);
        check("rst_ovf", int'(o_Overflow), 0);
        check("rst_busy", int'(o_Busy), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte into an empty FIFO: valid after the second edge.
        base = launch_cnt;
        exp_q.push_back(8'hA5);
        drive_cycle(1'b1, 8'hA5);
        check("single_dv_edge1", int'(o_TX_Data_Valid), 0);
        check("single_count_edge1", int'(o_Count), 1);
        drive_cycle(1'b0, 8'h00);
        check("single_dv_edge2", int'(o_TX_Data_Valid), 1);
        check("single_byte", int'(o_TX_Byte), 8'hA5);
        check("single_count_edge2", int'(o_Count), 0);
        drain("single", 1, 200);
        check("single_launches", launch_cnt - base, 1);

        // Back-to-back burst of three; first byte leaves before the third lands.
        base = launch_cnt;
        for (int i = 1; i <= 3; i++) exp_q.push_back(8'(i));
        drive_cycle(1'b1, 8'h01);
        check("burst_count_w1", int'(o_Count), 1);
        drive_cycle(1'b1, 8'h02);
        check("burst_count_w2", int'(o_Count), 1);
        drive_cycle(1'b1, 8'h03);
        check("burst_count_w3", int'(o_Count), 2);
        seq.delete();
        last_cnt = o_Count;
        waited   = 0;
        while (o_Count != 0 && waited < 1000) begin
            @(negedge clk);
            waited++;
            if (o_Count != last_cnt) begin
                seq.push_back(int'(o_Count));
                last_cnt = o_Count;
            end
        end
        check("burst_seq_len", seq.size(), 2);
        if (seq.size() == 2) begin
            check("burst_seq0", seq[0], 1);
            check("burst_seq1", seq[1], 0);
        end
        drain("burst", 3, 400);
        check("burst_launches", launch_cnt - base, 3);

        // Fill to full behind a long frame, then offer one more.
        cpb  = 40;
        base = launch_cnt;
        exp_q.push_back(8'h5A);
        drive_cycle(1'b1, 8'h5A);
        repeat (4) drive_cycle(1'b0, 8'h00);
        check("full_held_byte", int'(o_TX_Byte), 8'h5A);
        for (int r = 0; r < 10; r++) begin
            if (vecs[r].exp_acc) exp_q.push_back(vecs[r].data);
            drive_cycle(vecs[r].vld, vecs[r].data);
            check($sformatf("full_ready_r%0d", r), int'(o_Wr_Ready), int'(vecs[r].exp_ready));
            check($sformatf("full_count_r%0d", r), int'(o_Count), int'(vecs[r].exp_count));
            check($sformatf("full_ovf_r%0d", r), int'(o_Overflow), int'(vecs[r].exp_ovf));
        end
        drain("full", 9, 9 * (10 * 40 + 20));
        check("full_launches", launch_cnt - base, 9);
        cpb = 4;

        // Reset during the data bits of the second of three queued bytes.
        base = launch_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        drive_cycle(1'b1, 8'h11);
        drive_cycle(1'b1, 8'h22);
        drive_cycle(1'b1, 8'h33);
        waited = 0;
        while (launch_cnt < base + 2 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check("rst_mid_second_launch", launch_cnt - base, 2);
        repeat (3 * cpb) @(negedge clk);
        check("rst_mid_count_before", int'(o_Count), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_count", int'(o_Count), 0);
        check("rst_mid_dv", int'(o_TX_Data_Valid), 0);
        check("rst_mid_byte", int'(o_TX_Byte), 0);
        @(negedge clk);
        rst = 1'b0;
        drain("rst_mid", 2, 400);
        repeat (100) @(negedge clk);
        check("rst_mid_no_relaunch", launch_cnt - base, 2);
        check("rst_mid_count_after", int'(o_Count), 0);

        // Twenty bytes through the eight-deep FIFO so both pointers wrap.
        base   = launch_cnt;
        waited = 0;
        for (int i = 0; i < 20 && waited < 5000; ) begin
            if (o_Wr_Ready && $urandom_range(0, 3) != 0) begin
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                drive_cycle(1'b1, b);
                i++;
            end else begin
                drive_cycle(1'b0, 8'h00);
            end
            waited++;
        end
        drain("wrap", 20, 3000);
        check("wrap_launches", launch_cnt - base, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
